// File: rtl/stack_seq_ctrl.sv
// stack_seq_ctrl: multi-cycle sequencer for CALL, RET and interrupt entry.
// Each 32-bit PC transfer is split into two 16-bit stack accesses.
// CALL and INT push the high word first; RET pops the low word first.
// Optional feature macro: INT_SEQ_EN enables the interrupt pending latch,
// the INT1/INT2 sequence and intAck. When it is undefined, intReq is ignored.
module stack_seq_ctrl #(
  parameter logic [1:0] INT_VEC_SEL = 2'b11,
  parameter logic [1:0] FLUSH_CNT   = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       decValid,
  input  logic       opCall,
  input  logic       opRet,
  input  logic       intReq,
  output logic       stall,
  output logic [1:0] enablePushOrPop,
  output logic [1:0] firstTimeCall,
  output logic [1:0] firstTimeRET,
  output logic [1:0] firstTimeINT,
  output logic [1:0] FlashNum,
  output logic [1:0] pcSel,
  output logic       intAck
);

  typedef enum logic [2:0] {
    StIdle, StCall1, StCall2, StRet1, StRet2, StInt1, StInt2, StRedir
  } state_e;

  // Op type captured at start so REDIR knows which PC source to select.
  typedef enum logic [1:0] {
    OpCall = 2'b00,
    OpRet  = 2'b01,
    OpInt  = 2'b10
  } op_e;

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   int_start;

`ifdef INT_SEQ_EN
  logic int_pend_q, int_pend_d;

  // Pending latch: set by any sampled request, cleared when the INT redirect completes.
  // A request arriving while already pending merges into it.
  always_comb begin
    int_pend_d = int_pend_q | intReq;
    if (state_q == StRedir && op_q == OpInt) begin
      int_pend_d = 1'b0;
    end
  end

  // Pending request register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_pend_q <= 1'b0;
    end else begin
      int_pend_q <= int_pend_d;
    end
  end

  assign int_start = int_pend_q;
`else
  logic unused_int_req;
  assign unused_int_req = intReq;
  assign int_start      = 1'b0;
`endif

  // Next-state logic: starts are only evaluated in IDLE, everything else free-runs.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (int_start) begin
          state_d = StInt1;
          op_d    = OpInt;
        end else if (decValid && opCall) begin
          // CALL wins when both opCall and opRet are set.
          state_d = StCall1;
          op_d    = OpCall;
        end else if (decValid && opRet) begin
          state_d = StRet1;
          op_d    = OpRet;
        end
      end
      StCall1: state_d = StCall2;
      StCall2: state_d = StRedir;
      StRet1:  state_d = StRet2;
      StRet2:  state_d = StRedir;
      StInt1:  state_d = StInt2;
      StInt2:  state_d = StRedir;
      StRedir: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and op registers; reset abandons any half-done push without compensation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= OpCall;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Moore output decode from the state register; reset forces IDLE and thus zeros at once.
  always_comb begin
    stall           = 1'b0;
    enablePushOrPop = 2'b00;
    firstTimeCall   = 2'b00;
    firstTimeRET    = 2'b00;
    firstTimeINT    = 2'b00;
    FlashNum        = 2'b00;
    pcSel           = 2'b00;
    intAck          = 1'b0;
    unique case (state_q)
      StIdle: ;
      StCall1: begin
        stall           = 1'b1;
        enablePushOrPop = 2'b01;
        firstTimeCall   = 2'b01;
      end
      StCall2: begin
        stall           = 1'b1;
        enablePushOrPop = 2'b01;
        firstTimeCall   = 2'b10;
      end
      StRet1: begin
        stall           = 1'b1;
        enablePushOrPop = 2'b10;
        firstTimeRET    = 2'b01;
      end
      StRet2: begin
        stall           = 1'b1;
        enablePushOrPop = 2'b10;
        firstTimeRET    = 2'b10;
      end
      StInt1: begin
        stall           = 1'b1;
        enablePushOrPop = 2'b01;
        firstTimeINT    = 2'b01;
      end
      StInt2: begin
        stall           = 1'b1;
        enablePushOrPop = 2'b01;
        firstTimeINT    = 2'b10;
      end
      StRedir: begin
        FlashNum = FLUSH_CNT;
        unique case (op_q)
          OpCall:  pcSel = 2'b01;
          OpRet:   pcSel = 2'b10;
          OpInt: begin
            pcSel  = INT_VEC_SEL;
            intAck = 1'b1;
          end
          default: pcSel = 2'b00;
        endcase
      end
      default: ;
    endcase
`ifndef INT_SEQ_EN
    firstTimeINT = 2'b00;
    intAck       = 1'b0;
`endif
  end

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Directed bench for stack_seq_ctrl with an expected-output scoreboard.
// Build with INT_SEQ_EN defined to exercise the interrupt sequence.
module tb_stack_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       decValid;
  logic       opCall;
  logic       opRet;
  logic       intReq;
  logic       stall;
  logic [1:0] enablePushOrPop;
  logic [1:0] firstTimeCall;
  logic [1:0] firstTimeRET;
  logic [1:0] firstTimeINT;
  logic [1:0] FlashNum;
  logic [1:0] pcSel;
  logic       intAck;

  int tests_run = 0;
  int tests_failed = 0;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  stack_seq_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .decValid        (decValid),
    .opCall          (opCall),
    .opRet           (opRet),
    .intReq          (intReq),
    .stall           (stall),
    .enablePushOrPop (enablePushOrPop),
    .firstTimeCall   (firstTimeCall),
    .firstTimeRET    (firstTimeRET),
    .firstTimeINT    (firstTimeINT),
    .FlashNum        (FlashNum),
    .pcSel           (pcSel),
    .intAck          (intAck)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: stall, push/pop, call step, ret step, int step, flush, pcSel, ack.
  function automatic logic [13:0] mk(input logic st, input logic [1:0] pp, input logic [1:0] fc,
                                     input logic [1:0] fr, input logic [1:0] fi,
                                     input logic [1:0] fl, input logic [1:0] pc,
                                     input logic ack);
    return {st, pp, fc, fr, fi, fl, pc, ack};
  endfunction

  function automatic logic [13:0] observed();
    return {stall, enablePushOrPop, firstTimeCall, firstTimeRET, firstTimeINT, FlashNum,
            pcSel, intAck};
  endfunction

  task automatic push(input string tag, input logic [13:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [13:0] e;
    logic [13:0] o;
    string       t;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s: observed %b required %b", t, o, e);
    end
  endtask

  // One clock: inputs are consumed on the edge, then dropped, then outputs checked.
  task automatic tick();
    @(posedge clk);
    #1;
    decValid = 1'b0;
    opCall   = 1'b0;
    opRet    = 1'b0;
    intReq   = 1'b0;
    check_pop();
  endtask

  localparam logic [13:0] Zero  = 14'd0;
  localparam logic [13:0] Call1 = 14'b1_01_01_00_00_00_00_0;
  localparam logic [13:0] Call2 = 14'b1_01_10_00_00_00_00_0;
  localparam logic [13:0] Ret1  = 14'b1_10_00_01_00_00_00_0;
  localparam logic [13:0] Ret2  = 14'b1_10_00_10_00_00_00_0;
  localparam logic [13:0] RdCal = 14'b0_00_00_00_00_10_01_0;
  localparam logic [13:0] RdRet = 14'b0_00_00_00_00_10_10_0;

  initial begin
    reset    = 1'b1;
    decValid = 1'b0;
    opCall   = 1'b0;
    opRet    = 1'b0;
    intReq   = 1'b0;
    #1;
    push("reset_state", Zero);
    check_pop();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // CALL followed back-to-back by RET accepted in the first IDLE cycle.
    decValid = 1'b1;
    opCall   = 1'b1;
    push("call1", Call1);
    push("call2", Call2);
    push("call_redir", RdCal);
    push("call_idle", Zero);
    repeat (4) tick();
    decValid = 1'b1;
    opRet    = 1'b1;
    push("ret1", Ret1);
    push("ret2", Ret2);
    push("ret_redir", RdRet);
    push("ret_idle", Zero);
    repeat (4) tick();

    // Both opCall and opRet set: treated as CALL.
    decValid = 1'b1;
    opCall   = 1'b1;
    opRet    = 1'b1;
    push("both_call1", Call1);
    push("both_call2", Call2);
    push("both_redir", RdCal);
    push("both_idle", Zero);
    repeat (4) tick();

    // Op without decValid is ignored.
    opCall = 1'b1;
    opRet  = 1'b1;
    push("novalid_idle", Zero);
    tick();

    // Reset during CALL2: outputs drop before the next edge.
    decValid = 1'b1;
    opCall   = 1'b1;
    push("rst_call1", Call1);
    push("rst_call2", Call2);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    push("rst_async_zero", mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    check_pop();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push("post_rst_idle0", Zero);
    push("post_rst_idle1", Zero);
    repeat (2) tick();
    decValid = 1'b1;
    opCall   = 1'b1;
    push("post_rst_call1", Call1);
    push("post_rst_call2", Call2);
    push("post_rst_redir", RdCal);
    push("post_rst_idle", Zero);
    repeat (4) tick();

`ifdef INT_SEQ_EN
    // intReq with CALL in the same IDLE cycle: CALL first, then INT.
    decValid = 1'b1;
    opCall   = 1'b1;
    intReq   = 1'b1;
    push("ic_call1", Call1);
    push("ic_call2", Call2);
    push("ic_call_redir", RdCal);
    push("ic_idle", Zero);
    push("ic_int1", mk(1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
    push("ic_int2", mk(1'b1, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0));
    push("ic_int_redir", mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 1'b1));
    push("ic_int_idle", Zero);
    repeat (8) tick();

    // Single-cycle intReq in IDLE: latched on one edge, INT1 one cycle later.
    intReq = 1'b1;
    push("i_latch_idle", Zero);
    push("i_int1", mk(1'b1, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0));
    push("i_int2", mk(1'b1, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0));
    push("i_redir", mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 1'b1));
    push("i_idle0", Zero);
    push("i_idle1", Zero);
    repeat (6) tick();
`else
    // Interrupts disabled: a held intReq never produces an INT sequence.
    for (int i = 0; i < 10; i++) begin
      intReq = 1'b1;
      push($sformatf("noint_idle%0d", i), Zero);
      tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
